instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Control end of the program counter interface. Reads the instruction word that program ROM returns for the current PC address.
- Decodes flow-control opcodes and drives the PC's advance strobe, jump request and jump target.
- Hands datapath opcodes to the execution unit, one valid pulse per instruction.
- Provides conditional branches, a bounded call/return stack, a timed WAIT and HALT.

Parameters:
ADDR_W, 10, width of jump target, stack entries and pc_address low bits used
STACK_DEPTH, 4, return-address stack entries
INSTR_W, 16, instruction word width; [15:12] opcode, [11:0] operand

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
run  input  1  1 = sequence; 0 = hold in FETCH, no PC advance
instr_data  input  INSTR_W  synchronous ROM output, valid one clk after address changes
pc_address  input  12  current PC value
zero_flag  input  1  datapath zero flag, sampled in DECODE
carry_flag  input  1  datapath carry flag, sampled in DECODE
pc_enable  output  1  registered PC advance strobe (PC updates on its rising edge)
pc_jump  output  1  registered jump request to PC
pc_jump_addr  output  ADDR_W  registered jump target
exec_valid  output  1  one-cycle pulse: datapath opcode issued
exec_op  output  4  opcode accompanying exec_valid
exec_operand  output  12  operand accompanying exec_valid
halted  output  1  high while in HALT
stack_err  output  1  sticky over/underflow flag

Behaviour:
- Reset (async, active-high): state FETCH, all outputs 0, stack pointer 0, WAIT counter 0. Asserting reset mid-instruction (including WAIT or ADVANCE) aborts it; no pc_enable edge is produced afterwards.
- States: FETCH, DECODE, SETUP, ADVANCE, WAIT, HALT.
- FETCH: one cycle for ROM latency. Moves to DECODE if run=1, otherwise stays in FETCH.
- DECODE: samples instr_data and flags, then selects the next state.
- SETUP: pc_jump and pc_jump_addr are registered on the DECODE->SETUP edge (or the WAIT->SETUP edge) and held stable through SETUP and ADVANCE. They clear on the ADVANCE->FETCH edge.
- ADVANCE: pc_enable=1 for exactly this cycle, then FETCH.
- Nominal instruction cost: 4 cycles. The jump signals are therefore stable for at least one full cycle before pc_enable rises.
- Opcodes:
  - 0x0 NOP: advance.
  - 0x1 JMP: jump to operand[9:0].
  - 0x2 JZ: jump if zero_flag, else advance.
  - 0x3 JC: jump if carry_flag, else advance.
  - 0x4 CALL: push (pc_address[9:0]+1) mod 2^ADDR_W, then jump to operand[9:0].
  - 0x5 RET: pop the top entry, jump to it.
  - 0x6 WAIT n: n = operand; stay in WAIT exactly n cycles, then SETUP with no jump. n=0 goes directly to SETUP.
  - 0x7-0xE: exec_valid=1 for one cycle (the cycle after DECODE, i.e. SETUP), with exec_op/exec_operand from instr_data; then advance.
  - 0xF HALT: enter HALT, halted=1, no further pc_enable until reset.
- Stack boundaries:
  - CALL with STACK_DEPTH entries already used: no push, no jump (acts as NOP), stack_err set.
  - RET on empty stack: acts as NOP, stack_err set.
  - stack_err clears only on reset.
- Return-address wrap: 0x3FF+1 = 0x000.
- run deasserted: takes effect only in FETCH. An instruction already past FETCH completes.
- Flags are sampled only at DECODE; flag changes in later cycles do not affect the decision.

Test Plan:
- Reset, run=1, ROM all NOP -> pc_enable pulses every 4 cycles; pc_jump stays 0; outputs 0 during reset.
- ROM[0]=JMP 0x155 -> pc_jump=1 and pc_jump_addr=0x155 during SETUP and ADVANCE; single pc_enable pulse; both jump outputs clear in FETCH.
- JZ 0x020 with zero_flag=1 -> jump to 0x020. With zero_flag=0 -> pc_jump=0. Toggling zero_flag after DECODE has no effect.
- CALL 0x100 at address 0x010, then RET at 0x100 -> jump to 0x011. Five nested CALLs -> 5th is a NOP and stack_err=1. RET on empty -> stack_err=1.
- WAIT 3 -> exactly 7 cycles between pc_enable pulses. WAIT 0 -> 4 cycles. Reset asserted mid-WAIT -> no pc_enable; state FETCH after release.
- Opcode 0x9 operand 0xABC -> exec_valid for one cycle with exec_op=0x9, exec_operand=0xABC. HALT -> halted=1 and no pc_enable for 50 cycles.

Source files
------------

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction fetch/decode sequencer driving the PC and execution unit
//
// Ports:
//   clk           system clock, all state on rising edge
//   reset         asynchronous, active-high; clears all state and outputs
//   run           1 = sequence instructions; 0 = hold in FETCH
//   instr_data    synchronous ROM word for the current PC ([15:12] opcode, [11:0] operand)
//   pc_address    current PC value (low ADDR_W bits used for return addresses)
//   zero_flag     datapath zero flag, sampled in DECODE
//   carry_flag    datapath carry flag, sampled in DECODE
//   pc_enable     registered PC advance strobe, high for the ADVANCE cycle only
//   pc_jump       registered jump request, valid through SETUP and ADVANCE
//   pc_jump_addr  registered jump target, valid with pc_jump
//   exec_valid    one-cycle pulse (SETUP) issuing a datapath opcode
//   exec_op       opcode accompanying exec_valid
//   exec_operand  operand accompanying exec_valid
//   halted        high while in HALT
//   stack_err     sticky call-stack overflow/underflow flag

module instr_sequencer #(
   parameter int ADDR_W      = 10,
   parameter int STACK_DEPTH = 4,
   parameter int INSTR_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic [INSTR_W-1:0] instr_data,
   input  logic [11:0]        pc_address,
   input  logic               zero_flag,
   input  logic               carry_flag,
   output logic               pc_enable,
   output logic               pc_jump,
   output logic [ADDR_W-1:0]  pc_jump_addr,
   output logic               exec_valid,
   output logic [3:0]         exec_op,
   output logic [11:0]        exec_operand,
   output logic               halted,
   output logic               stack_err
);

   localparam logic [2:0] S_FETCH   = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_SETUP   = 3'd2;
   localparam logic [2:0] S_ADVANCE = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_HALT    = 3'd5;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'h1;
   localparam logic [3:0] OP_JZ   = 4'h2;
   localparam logic [3:0] OP_JC   = 4'h3;
   localparam logic [3:0] OP_CALL = 4'h4;
   localparam logic [3:0] OP_RET  = 4'h5;
   localparam logic [3:0] OP_WAIT = 4'h6;
   localparam logic [3:0] OP_HALT = 4'hF;

   // sp counts used entries, so it needs one more code than STACK_DEPTH
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [2:0]        state;
   logic [11:0]       wait_cnt;
   logic [SP_W-1:0]   sp;
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

   logic [3:0]        opcode;
   logic [11:0]       operand;
   logic [SP_W-1:0]   sp_m1;
   logic [ADDR_W-1:0] ret_addr;

   logic              dec_jump;
   logic [ADDR_W-1:0] dec_target;
   logic              dec_push;
   logic              dec_pop;
   logic              dec_err;
   logic              dec_exec;
   logic [2:0]        dec_next;

   // PC bits above the jump range never feed a return address
   logic unused_pc_hi;
   assign unused_pc_hi = ^pc_address[11:ADDR_W];

   assign opcode   = instr_data[INSTR_W-1 -: 4];
   assign operand  = instr_data[11:0];
   assign sp_m1    = sp - SP_W'(1);
   // wraps naturally at 2^ADDR_W
   assign ret_addr = pc_address[ADDR_W-1:0] + ADDR_W'(1);

   // Decision for the instruction sitting in DECODE; only consumed in that state
   always_comb begin
      dec_jump   = 1'b0;
      dec_target = '0;
      dec_push   = 1'b0;
      dec_pop    = 1'b0;
      dec_err    = 1'b0;
      dec_exec   = 1'b0;
      dec_next   = S_SETUP;
      case (opcode)
         OP_NOP: ;
         OP_JMP: begin
            dec_jump   = 1'b1;
            dec_target = operand[ADDR_W-1:0];
         end
         OP_JZ: begin
            dec_jump   = zero_flag;
            dec_target = zero_flag ? operand[ADDR_W-1:0] : '0;
         end
         OP_JC: begin
            dec_jump   = carry_flag;
            dec_target = carry_flag ? operand[ADDR_W-1:0] : '0;
         end
         OP_CALL: begin
            // full stack: the call degrades to a NOP
            if (sp == SP_W'(STACK_DEPTH)) begin
               dec_err = 1'b1;
            end else begin
               dec_push   = 1'b1;
               dec_jump   = 1'b1;
               dec_target = operand[ADDR_W-1:0];
            end
         end
         OP_RET: begin
            if (sp == '0) begin
               dec_err = 1'b1;
            end else begin
               dec_pop    = 1'b1;
               dec_jump   = 1'b1;
               dec_target = stack_mem[sp_m1[IDX_W-1:0]];
            end
         end
         OP_WAIT: begin
            if (operand != 12'd0) dec_next = S_WAIT;
         end
         OP_HALT: dec_next = S_HALT;
         default: dec_exec = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_FETCH;
         wait_cnt     <= '0;
         sp           <= '0;
         pc_enable    <= 1'b0;
         pc_jump      <= 1'b0;
         pc_jump_addr <= '0;
         exec_valid   <= 1'b0;
         exec_op      <= '0;
         exec_operand <= '0;
         halted       <= 1'b0;
         stack_err    <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
      end else begin
         // exec fields are only meaningful for the single SETUP cycle
         exec_valid   <= 1'b0;
         exec_op      <= '0;
         exec_operand <= '0;
         case (state)
            S_FETCH: begin
               if (run) state <= S_DECODE;
            end
            S_DECODE: begin
               state        <= dec_next;
               pc_jump      <= dec_jump;
               pc_jump_addr <= dec_target;
               if (dec_next == S_HALT) halted <= 1'b1;
               if (dec_next == S_WAIT) wait_cnt <= operand;
               if (dec_push) begin
                  stack_mem[sp[IDX_W-1:0]] <= ret_addr;
                  sp <= sp + SP_W'(1);
               end
               if (dec_pop) sp <= sp_m1;
               if (dec_err) stack_err <= 1'b1;
               if (dec_exec) begin
                  exec_valid   <= 1'b1;
                  exec_op      <= opcode;
                  exec_operand <= operand;
               end
            end
            S_WAIT: begin
               // loaded with n, leaves after exactly n cycles here
               if (wait_cnt == 12'd1) begin
                  state    <= S_SETUP;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt - 12'd1;
               end
            end
            S_SETUP: begin
               state     <= S_ADVANCE;
               pc_enable <= 1'b1;
            end
            S_ADVANCE: begin
               state        <= S_FETCH;
               pc_enable    <= 1'b0;
               pc_jump      <= 1'b0;
               pc_jump_addr <= '0;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer

module tb_instr_sequencer;

   logic        clk;
   logic        reset;
   logic        run;
   logic [15:0] instr_data;
   logic [11:0] pc_address;
   logic        zero_flag;
   logic        carry_flag;
   logic        pc_enable;
   logic        pc_jump;
   logic [9:0]  pc_jump_addr;
   logic        exec_valid;
   logic [3:0]  exec_op;
   logic [11:0] exec_operand;
   logic        halted;
   logic        stack_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [15:0] rom [1024];
   logic [11:0] pc;

   instr_sequencer #(.ADDR_W(10), .STACK_DEPTH(4), .INSTR_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .instr_data   (instr_data),
      .pc_address   (pc_address),
      .zero_flag    (zero_flag),
      .carry_flag   (carry_flag),
      .pc_enable    (pc_enable),
      .pc_jump      (pc_jump),
      .pc_jump_addr (pc_jump_addr),
      .exec_valid   (exec_valid),
      .exec_op      (exec_op),
      .exec_operand (exec_operand),
      .halted       (halted),
      .stack_err    (stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // program counter and synchronous ROM model
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pc         <= 12'd0;
         instr_data <= 16'h0000;
      end else begin
         if (pc_enable) pc <= pc_jump ? {2'b00, pc_jump_addr} : pc + 12'd1;
         instr_data <= rom[pc[9:0]];
      end
   end
   assign pc_address = pc;

   task automatic clear_rom();
      for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
   endtask

   task automatic apply_reset(input logic r);
      @(negedge clk);
      reset = 1'b1;
      run   = r;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_pulse(output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pc_enable) begin
            t  = cyc;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] outs;
      clear_rom();
      zero_flag = 1'b0;
      carry_flag = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run   = 1'b1;
      repeat (3) @(negedge clk);
      outs = {pc_enable, pc_jump, pc_jump_addr, exec_valid, exec_op, exec_operand, halted, stack_err};
      n_tests++;
      if (outs !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
   endtask

   task automatic test_nop();
      int c0, t1, t2, t3;
      bit ok1, ok2, ok3;
      clear_rom();
      apply_reset(1'b1);
      c0 = cyc;
      wait_pulse(t1, ok1);
      n_tests++;
      if (!ok1 || t1 != c0 + 3) begin
         n_fail++;
         $display("FAIL nop_first_pulse: got cycle %0d (ok=%0d) expected %0d", t1, ok1, c0 + 3);
      end
      @(negedge clk);
      n_tests++;
      if (pc_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL nop_pulse_width: pc_enable got %b expected 0", pc_enable);
      end
      wait_pulse(t2, ok2);
      wait_pulse(t3, ok3);
      n_tests++;
      if (!ok2 || !ok3 || t2 - t1 != 4 || t3 - t2 != 4) begin
         n_fail++;
         $display("FAIL nop_interval: got %0d,%0d expected 4,4", t2 - t1, t3 - t2);
      end
      n_tests++;
      if (pc_jump !== 1'b0 || pc_address !== 12'd2) begin
         n_fail++;
         $display("FAIL nop_pc: got jump=%b pc=%h expected jump=0 pc=002", pc_jump, pc_address);
      end
   endtask

   task automatic test_jmp();
      clear_rom();
      rom[0] = 16'h1155;
      apply_reset(1'b1);
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (pc_jump !== 1'b1 || pc_jump_addr !== 10'h155 || pc_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL jmp_setup: got jump=%b addr=%h en=%b expected 1/155/0", pc_jump, pc_jump_addr, pc_enable);
      end
      @(negedge clk);
      n_tests++;
      if (pc_jump !== 1'b1 || pc_jump_addr !== 10'h155 || pc_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL jmp_advance: got jump=%b addr=%h en=%b expected 1/155/1", pc_jump, pc_jump_addr, pc_enable);
      end
      @(negedge clk);
      n_tests++;
      if (pc_jump !== 1'b0 || pc_jump_addr !== 10'h000 || pc_enable !== 1'b0 || pc_address !== 12'h155) begin
         n_fail++;
         $display("FAIL jmp_fetch: got jump=%b addr=%h en=%b pc=%h expected 0/000/0/155",
                  pc_jump, pc_jump_addr, pc_enable, pc_address);
      end
   endtask

   task automatic test_cond_branch();
      int t;
      bit ok;
      // JZ taken; flag drops after DECODE
      clear_rom();
      rom[0] = 16'h2020;
      zero_flag = 1'b1;
      carry_flag = 1'b0;
      apply_reset(1'b1);
      @(negedge clk);
      @(negedge clk);
      zero_flag = 1'b0;
      wait_pulse(t, ok);
      @(negedge clk);
      n_tests++;
      if (!ok || pc_address !== 12'h020) begin
         n_fail++;
         $display("FAIL jz_taken: got pc=%h ok=%0d expected 020", pc_address, ok);
      end
      // JZ not taken; flag rises after DECODE
      zero_flag = 1'b0;
      apply_reset(1'b1);
      @(negedge clk);
      @(negedge clk);
      zero_flag = 1'b1;
      wait_pulse(t, ok);
      n_tests++;
      if (!ok || pc_jump !== 1'b0) begin
         n_fail++;
         $display("FAIL jz_not_taken: got jump=%b ok=%0d expected 0", pc_jump, ok);
      end
      @(negedge clk);
      n_tests++;
      if (pc_address !== 12'h001) begin
         n_fail++;
         $display("FAIL jz_not_taken_pc: got %h expected 001", pc_address);
      end
      // JC follows carry, not zero
      rom[0] = 16'h3077;
      zero_flag = 1'b1;
      carry_flag = 1'b0;
      apply_reset(1'b1);
      wait_pulse(t, ok);
      n_tests++;
      if (!ok || pc_jump !== 1'b0) begin
         n_fail++;
         $display("FAIL jc_not_taken: got jump=%b expected 0", pc_jump);
      end
      zero_flag = 1'b0;
      carry_flag = 1'b1;
      apply_reset(1'b1);
      wait_pulse(t, ok);
      n_tests++;
      if (!ok || pc_jump !== 1'b1 || pc_jump_addr !== 10'h077) begin
         n_fail++;
         $display("FAIL jc_taken: got jump=%b addr=%h expected 1/077", pc_jump, pc_jump_addr);
      end
      carry_flag = 1'b0;
   endtask

   task automatic test_call_ret();
      int t;
      bit ok;
      clear_rom();
      rom[0]      = 16'h1010;
      rom[12'h10] = 16'h4100;
      rom[12'h100] = 16'h5000;
      apply_reset(1'b1);
      wait_pulse(t, ok);
      wait_pulse(t, ok);
      n_tests++;
      if (!ok || pc_jump !== 1'b1 || pc_jump_addr !== 10'h100) begin
         n_fail++;
         $display("FAIL call_jump: got jump=%b addr=%h expected 1/100", pc_jump, pc_jump_addr);
      end
      wait_pulse(t, ok);
      n_tests++;
      if (!ok || pc_jump !== 1'b1 || pc_jump_addr !== 10'h011 || stack_err !== 1'b0) begin
         n_fail++;
         $display("FAIL ret_jump: got jump=%b addr=%h err=%b expected 1/011/0", pc_jump, pc_jump_addr, stack_err);
      end
      // return address wraps at the top of the address space
      clear_rom();
      rom[0]       = 16'h13FF;
      rom[12'h3FF] = 16'h4050;
      rom[12'h050] = 16'h5000;
      apply_reset(1'b1);
      repeat (3) wait_pulse(t, ok);
      n_tests++;
      if (!ok || pc_jump !== 1'b1 || pc_jump_addr !== 10'h000) begin
         n_fail++;
         $display("FAIL ret_wrap: got jump=%b addr=%h expected 1/000", pc_jump, pc_jump_addr);
      end
   endtask

   task automatic test_stack_bounds();
      int t;
      bit ok;
      clear_rom();
      rom[0] = 16'h4001;
      rom[1] = 16'h4002;
      rom[2] = 16'h4003;
      rom[3] = 16'h4004;
      rom[4] = 16'h4200;
      rom[5] = 16'h5000;
      apply_reset(1'b1);
      repeat (4) wait_pulse(t, ok);
      n_tests++;
      if (!ok || stack_err !== 1'b0) begin
         n_fail++;
         $display("FAIL stack_four_calls: got err=%b expected 0", stack_err);
      end
      wait_pulse(t, ok);
      n_tests++;
      if (!ok || pc_jump !== 1'b0 || stack_err !== 1'b1) begin
         n_fail++;
         $display("FAIL stack_overflow: got jump=%b err=%b expected 0/1", pc_jump, stack_err);
      end
      wait_pulse(t, ok);
      n_tests++;
      if (!ok || pc_address !== 12'h005 || pc_jump_addr !== 10'h004 || stack_err !== 1'b1) begin
         n_fail++;
         $display("FAIL stack_ret_after_overflow: got pc=%h addr=%h err=%b expected 005/004/1",
                  pc_address, pc_jump_addr, stack_err);
      end
      // RET on empty stack; reset must also have cleared the sticky flag
      clear_rom();
      rom[0] = 16'h5000;
      apply_reset(1'b1);
      n_tests++;
      if (stack_err !== 1'b0) begin
         n_fail++;
         $display("FAIL stack_err_reset: got %b expected 0", stack_err);
      end
      wait_pulse(t, ok);
      n_tests++;
      if (!ok || pc_jump !== 1'b0 || stack_err !== 1'b1) begin
         n_fail++;
         $display("FAIL stack_underflow: got jump=%b err=%b expected 0/1", pc_jump, stack_err);
      end
   endtask

   task automatic test_wait();
      int c0, t1, t2, t3, t4, cnt;
      bit ok1, ok2, ok3, ok4;
      clear_rom();
      rom[0] = 16'h6003;
      rom[1] = 16'h6003;
      rom[2] = 16'h6000;
      rom[3] = 16'h6000;
      apply_reset(1'b1);
      c0 = cyc;
      wait_pulse(t1, ok1);
      wait_pulse(t2, ok2);
      wait_pulse(t3, ok3);
      wait_pulse(t4, ok4);
      n_tests++;
      if (!ok1 || t1 != c0 + 6 || !ok2 || t2 - t1 != 7) begin
         n_fail++;
         $display("FAIL wait3_timing: got first=%0d interval=%0d expected %0d/7", t1 - c0, t2 - t1, 6);
      end
      n_tests++;
      if (!ok3 || !ok4 || t3 - t2 != 4 || t4 - t3 != 4) begin
         n_fail++;
         $display("FAIL wait0_timing: got %0d,%0d expected 4,4", t3 - t2, t4 - t3);
      end
      // reset in the middle of a long WAIT
      clear_rom();
      rom[0] = 16'h6064;
      apply_reset(1'b1);
      repeat (10) @(negedge clk);
      #2;
      reset = 1'b1;
      run   = 1'b0;
      #1;
      n_tests++;
      if (pc_enable !== 1'b0 || pc_jump !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_reset_async: got en=%b jump=%b expected 0/0", pc_enable, pc_jump);
      end
      rom[0] = 16'h0000;
      @(negedge clk);
      reset = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (pc_enable) cnt++;
      end
      n_tests++;
      if (cnt != 0) begin
         n_fail++;
         $display("FAIL wait_reset_no_pulse: got %0d pulses expected 0", cnt);
      end
      run = 1'b1;
      c0 = cyc;
      wait_pulse(t1, ok1);
      n_tests++;
      if (!ok1 || t1 != c0 + 3) begin
         n_fail++;
         $display("FAIL wait_reset_fetch: got %0d cycles expected 3", t1 - c0);
      end
   endtask

   task automatic test_exec();
      clear_rom();
      rom[0] = 16'h9ABC;
      apply_reset(1'b1);
      @(negedge clk);
      n_tests++;
      if (exec_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL exec_early: got valid=%b expected 0", exec_valid);
      end
      @(negedge clk);
      n_tests++;
      if (exec_valid !== 1'b1 || exec_op !== 4'h9 || exec_operand !== 12'hABC) begin
         n_fail++;
         $display("FAIL exec_issue: got %b/%h/%h expected 1/9/abc", exec_valid, exec_op, exec_operand);
      end
      @(negedge clk);
      n_tests++;
      if (exec_valid !== 1'b0 || pc_enable !== 1'b1 || pc_jump !== 1'b0) begin
         n_fail++;
         $display("FAIL exec_one_cycle: got valid=%b en=%b jump=%b expected 0/1/0", exec_valid, pc_enable, pc_jump);
      end
   endtask

   task automatic test_halt();
      int cnt;
      clear_rom();
      rom[0] = 16'hF000;
      apply_reset(1'b1);
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (halted !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_enter: got %b expected 1", halted);
      end
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (pc_enable) cnt++;
      end
      n_tests++;
      if (cnt != 0 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_hold: got pulses=%0d halted=%b expected 0/1", cnt, halted);
      end
      apply_reset(1'b0);
      n_tests++;
      if (halted !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_reset: got %b expected 0", halted);
      end
   endtask

   task automatic test_run_hold();
      int cnt, c0, t;
      bit ok;
      clear_rom();
      apply_reset(1'b0);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (pc_enable) cnt++;
      end
      n_tests++;
      if (cnt != 0) begin
         n_fail++;
         $display("FAIL run_low_hold: got %0d pulses expected 0", cnt);
      end
      run = 1'b1;
      c0 = cyc;
      @(negedge clk);
      run = 1'b0;
      wait_pulse(t, ok);
      n_tests++;
      if (!ok || t != c0 + 3) begin
         n_fail++;
         $display("FAIL run_drop_completes: got %0d cycles ok=%0d expected 3", t - c0, ok);
      end
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (pc_enable) cnt++;
      end
      n_tests++;
      if (cnt != 0 || pc_address !== 12'h001) begin
         n_fail++;
         $display("FAIL run_drop_stops: got pulses=%0d pc=%h expected 0/001", cnt, pc_address);
      end
   endtask

   initial begin
      reset      = 1'b1;
      run        = 1'b0;
      zero_flag  = 1'b0;
      carry_flag = 1'b0;
      test_reset();
      test_nop();
      test_jmp();
      test_cond_branch();
      test_call_ret();
      test_stack_bounds();
      test_wait();
      test_exec();
      test_halt();
      test_run_hold();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
